gray_wptr_gen: RTL and testbench
================================

Name: gray_wptr_gen

Overview:
- Write-side pointer generator for the asynchronous FIFO. Counterpart to the read-side Gray-to-binary decode.
- Keeps a binary write pointer and derives a registered, glitch-free Gray-coded copy that is safe to send across to the read clock domain.
- Produces the RAM write address, a registered full flag and a fill level. These are computed against the read pointer, which the read domain's synchronizer has already brought into this domain in Gray code.

Parameters:
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W; pointer width PW = ADDR_W+1.

Ports:
- clk  input  1  write-domain clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_inc  input  1  write request for this cycle.
- rptr_gray_sync  input  PW  read pointer in Gray code, already synchronized into clk domain.
- waddr  output  ADDR_W  RAM write address = wbin[ADDR_W-1:0].
- wptr_gray  output  PW  registered Gray write pointer, to the read-domain synchronizer.
- full  output  1  registered full flag.
- wr_used  output  PW  registered fill level, range 0..2**ADDR_W.
- wr_accept  output  1  combinational: wr_inc & ~full; qualifies the RAM write enable.

Behaviour:
- State registers:
  - wbin[PW-1:0], binary write pointer.
  - wgray[PW-1:0], drives wptr_gray.
  - full_q.
  - used_q.
- Reset (rst=1 on a clk edge): wbin=0, wgray=0, full_q=0, used_q=0.
  - Outputs after reset: waddr=0, wptr_gray=0, full=0, wr_used=0.
  - rst overrides wr_inc in the same cycle.
  - Reset mid-operation discards all pointer state on that edge; no partial update.
- Next-state logic:
  - wbin_next = wbin + (wr_inc & ~full_q), modulo 2**PW. Natural wrap from all-ones to 0; no saturation.
  - wgray_next = wbin_next ^ (wbin_next >> 1). Registered, never driven combinationally, so wptr_gray changes by exactly one bit per increment.
  - rbin = Gray-to-binary of rptr_gray_sync, combinational: rbin[i] = XOR of rptr_gray_sync[PW-1:i].
  - full_next = (wgray_next == {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]}).
    - For ADDR_W=1 the low slice is empty; compare the 2 MSBs only.
  - used_next = (wbin_next - rbin) mod 2**PW.
- Latency:
  - An accepted write updates waddr, wptr_gray, full and wr_used on the next clk edge.
  - A change on rptr_gray_sync reaches full and wr_used one edge later, with no wr_inc needed.
- wr_inc while full=1: ignored. Pointer, Gray value and used do not change; wr_accept=0.
- Write and read advance in the same cycle: both terms are evaluated from the same-cycle values, so full may stay 1 or clear depending on the new rptr. Never stale by more than one edge.
- Full is pessimistic: rptr_gray_sync lags the true read pointer. This is acceptable. full must never be 0 while used = 2**ADDR_W.
- Invariants, checked by assertions:
  - wptr_gray changes in at most 1 bit per cycle.
  - full == (wr_used == 2**ADDR_W).
  - wr_used <= 2**ADDR_W.

Test Plan:
- Reset: ADDR_W=2, drive wr_inc=1, rst=1 for 2 cycles -> waddr=0, wptr_gray=000, full=0, wr_used=0.
- Fill: ADDR_W=2, rptr_gray_sync=000, 4 consecutive wr_inc.
  - wptr_gray sequence 001, 011, 010, 110.
  - waddr sequence 1, 2, 3, 0.
  - wr_used sequence 1, 2, 3, 4.
  - full=1 on the same edge wptr_gray becomes 110.
- Write while full: continue from Fill, wr_inc=1 for 3 cycles -> wr_accept=0; wptr_gray stays 110, wr_used 4, full 1.
- Drain release: from full, set rptr_gray_sync=001 (rbin=1) with wr_inc=0 -> next edge full=0, wr_used=3. Then one wr_inc -> wptr_gray=111, full=1, wr_used=4.
- Wrap-around: ADDR_W=2, 9 accepted writes while rptr tracks wbin-1 -> wbin wraps 7->0 (wptr_gray 100 -> 000); wr_used stays 1; full never asserts; single-bit Gray change assertion holds across the wrap.
- Mid-operation reset: assert rst with wbin=5, full=0, wr_inc=1 -> next edge all outputs 0. First accepted write after release -> wptr_gray=001.

Source files
------------

// File: rtl/gray_wptr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_wptr_gen_if
// Description : Bundle between the async-FIFO write-side pointer generator and
//               its user. The slave modport is the pointer generator; the
//               master modport is whoever issues writes and owns the RAM.
//   wr_inc          master->slave  write request this cycle
//   rptr_gray_sync  master->slave  Gray read pointer, already in clk domain
//   waddr           slave->master  RAM write address
//   wptr_gray       slave->master  registered Gray write pointer (to CDC sync)
//   full            slave->master  registered full flag
//   wr_used         slave->master  registered fill level 0..2**ADDR_W
//   wr_accept       slave->master  wr_inc & ~full, qualifies RAM write enable
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_wptr_gen_if #(
    parameter int ADDR_W = 4
);
    localparam int c_PW = ADDR_W + 1;

    logic              wr_inc;
    logic [c_PW-1:0]   rptr_gray_sync;
    logic [ADDR_W-1:0] waddr;
    logic [c_PW-1:0]   wptr_gray;
    logic              full;
    logic [c_PW-1:0]   wr_used;
    logic              wr_accept;

    modport master (
        output wr_inc,
        output rptr_gray_sync,
        input  waddr,
        input  wptr_gray,
        input  full,
        input  wr_used,
        input  wr_accept
    );

    modport slave (
        input  wr_inc,
        input  rptr_gray_sync,
        output waddr,
        output wptr_gray,
        output full,
        output wr_used,
        output wr_accept
    );
endinterface
`default_nettype wire

// File: rtl/gray_wptr_gen.sv
`default_nettype none
// ============================================================================
// Module      : gray_wptr_gen
// Description : Write-side pointer generator for an asynchronous FIFO. Holds a
//               binary write pointer, a registered Gray copy for the read
//               clock domain, and registered full / fill-level outputs that
//               are computed against the already-synchronized Gray read
//               pointer.
//   clk  : write-domain clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gray_wptr_gen_if.slave (wr_inc, rptr_gray_sync in;
//          waddr, wptr_gray, full, wr_used, wr_accept out)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_wptr_gen #(
    parameter int ADDR_W = 4
) (
    input  wire               clk,
    input  wire               rst,
    gray_wptr_gen_if.slave    bus
);
    localparam int            c_PW    = ADDR_W + 1;
    localparam logic [c_PW-1:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [c_PW-1:0] r_wbin_q,  w_wbin_d;
    logic [c_PW-1:0] r_wgray_q, w_wgray_d;
    logic            r_full_q,  w_full_d;
    logic [c_PW-1:0] r_used_q,  w_used_d;

    logic            w_accept;
    logic [c_PW-1:0] w_rbin;
    logic [c_PW-1:0] w_full_pat;

    // Gray read pointer with its two MSBs inverted: the value our Gray write
    // pointer takes when it is exactly one full lap ahead of the read pointer.
    generate
        if (ADDR_W >= 2) begin : g_full_pat_wide
            assign w_full_pat = {~bus.rptr_gray_sync[c_PW-1:c_PW-2],
                                  bus.rptr_gray_sync[c_PW-3:0]};
        end else begin : g_full_pat_narrow
            assign w_full_pat = ~bus.rptr_gray_sync;
        end
    endgenerate

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < c_PW; i++) begin
            w_rbin[i] = ^(bus.rptr_gray_sync >> i);
        end
    end

    always_comb begin
        w_accept  = bus.wr_inc & ~r_full_q;
        w_wbin_d  = r_wbin_q + {{ADDR_W{1'b0}}, w_accept};
        // Gray value is registered so the CDC path sees a single-bit change.
        w_wgray_d = w_wbin_d ^ (w_wbin_d >> 1);
        w_full_d  = (w_wgray_d == w_full_pat);
        w_used_d  = w_wbin_d - w_rbin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin_q  <= '0;
            r_wgray_q <= '0;
            r_full_q  <= 1'b0;
            r_used_q  <= '0;
        end else begin
            r_wbin_q  <= w_wbin_d;
            r_wgray_q <= w_wgray_d;
            r_full_q  <= w_full_d;
            r_used_q  <= w_used_d;
        end
    end

    assign bus.waddr     = r_wbin_q[ADDR_W-1:0];
    assign bus.wptr_gray = r_wgray_q;
    assign bus.full      = r_full_q;
    assign bus.wr_used   = r_used_q;
    assign bus.wr_accept = w_accept;

    // Invariants. The Gray check skips the edge right after reset, where the
    // pointer is cleared rather than incremented.
    a_gray_one_bit : assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> ($countones(r_wgray_q ^ $past(r_wgray_q)) <= 1));
    a_full_matches_used : assert property (@(posedge clk) disable iff (rst)
        r_full_q == (r_used_q == c_DEPTH));
    a_used_in_range : assert property (@(posedge clk) disable iff (rst)
        r_used_q <= c_DEPTH);
endmodule
`default_nettype wire

// File: tb/tb_gray_wptr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_wptr_gen
// Description : Self-checking bench for gray_wptr_gen with ADDR_W=2. Runs a
//               table of directed vectors (reset, fill, write-while-full,
//               drain release), then hand-written wrap-around and mid-run
//               reset sequences, with a per-cycle invariant monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_wptr_gen;
    localparam int c_AW = 2;
    localparam int c_PW = c_AW + 1;

    typedef struct {
        logic             rst;
        logic             inc;
        logic [c_PW-1:0]  rptr;
        logic             chk_acc;
        logic             acc;
        logic [c_AW-1:0]  waddr;
        logic [c_PW-1:0]  gray;
        logic             full;
        logic [c_PW-1:0]  used;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    gray_wptr_gen_if #(.ADDR_W(c_AW)) bus ();

    gray_wptr_gen #(.ADDR_W(c_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [c_PW-1:0] bin2gray(input logic [c_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk_outs(input string tag, input int waddr, input int gray,
                            input int full, input int used);
        chk({tag, ".waddr"},     int'(bus.waddr),     waddr);
        chk({tag, ".wptr_gray"}, int'(bus.wptr_gray), gray);
        chk({tag, ".full"},      int'(bus.full),      full);
        chk({tag, ".wr_used"},   int'(bus.wr_used),   used);
    endtask

    // Invariant monitor, sampled on the falling edge.
    logic [c_PW-1:0] mon_prev_gray = '0;
    logic            mon_prev_rst  = 1'b1;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("inv.full_eq_used", int'(bus.full), int'(bus.wr_used == 3'd4));
            chk("inv.used_le_depth", int'(bus.wr_used <= 3'd4), 1);
            if (!mon_prev_rst)
                chk("inv.gray_one_bit",
                    int'($countones(bus.wptr_gray ^ mon_prev_gray) <= 1), 1);
        end
        mon_prev_gray = bus.wptr_gray;
        mon_prev_rst  = rst;
    end

    vec_t vecs [11];
    logic [c_PW-1:0] m_wbin;

    initial begin
        // rst inc rptr chk_acc acc waddr gray full used
        vecs[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'd1, 3'b001, 1'b0, 3'd1};
        vecs[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'd2, 3'b011, 1'b0, 3'd2};
        vecs[4]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'd3, 3'b010, 1'b0, 3'd3};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 3'b110, 1'b1, 3'd4};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 3'b110, 1'b1, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 3'b110, 1'b0, 3'd3};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 2'd1, 3'b111, 1'b1, 3'd4};

        bus.wr_inc         = 1'b0;
        bus.rptr_gray_sync = '0;

        for (int i = 0; i < 11; i++) begin
            rst                = vecs[i].rst;
            bus.wr_inc         = vecs[i].inc;
            bus.rptr_gray_sync = vecs[i].rptr;
            #1;
            if (vecs[i].chk_acc)
                chk($sformatf("vec%0d.wr_accept", i), int'(bus.wr_accept), int'(vecs[i].acc));
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            chk_outs($sformatf("vec%0d", i), int'(vecs[i].waddr), int'(vecs[i].gray),
                     int'(vecs[i].full), int'(vecs[i].used));
        end

        // Wrap-around: wbin=5. Move rptr to wbin-1, then write 9 times while
        // the read pointer trails by one, crossing 7->0.
        m_wbin             = 3'd5;
        bus.wr_inc         = 1'b0;
        bus.rptr_gray_sync = bin2gray(m_wbin - 3'd1);
        @(posedge clk);
        #1;
        chk_outs("wrap.setup", 1, 3'b111, 0, 1);
        for (int k = 0; k < 9; k++) begin
            bus.wr_inc         = 1'b1;
            bus.rptr_gray_sync = bin2gray(m_wbin);
            #1;
            chk($sformatf("wrap%0d.wr_accept", k), int'(bus.wr_accept), 1);
            @(posedge clk);
            #1;
            m_wbin = m_wbin + 3'd1;
            chk_outs($sformatf("wrap%0d", k), int'(m_wbin[c_AW-1:0]),
                     int'(bin2gray(m_wbin)), 0, 1);
        end
        chk("wrap.final_gray", int'(bus.wptr_gray), int'(3'b101));

        // Mid-operation reset: bring wbin to 5 with full=0, then reset while
        // still requesting a write.
        rst        = 1'b1;
        bus.wr_inc = 1'b0;
        bus.rptr_gray_sync = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_wbin = '0;
        for (int k = 0; k < 5; k++) begin
            bus.wr_inc         = 1'b1;
            bus.rptr_gray_sync = bin2gray(m_wbin);
            @(posedge clk);
            #1;
            m_wbin = m_wbin + 3'd1;
        end
        chk_outs("mid.pre", 1, 3'b111, 0, 1);
        rst        = 1'b1;
        bus.wr_inc = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("mid.rst", 0, 3'b000, 0, 0);
        rst                = 1'b0;
        bus.wr_inc         = 1'b1;
        bus.rptr_gray_sync = '0;
        #1;
        chk("mid.first.wr_accept", int'(bus.wr_accept), 1);
        @(posedge clk);
        #1;
        chk_outs("mid.first", 1, 3'b001, 0, 1);

        bus.wr_inc = 1'b0;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
